// File: rtl/mem_responder.sv
// Purpose: multi-channel memory model with per-channel read/write FSMs, storage array and host preload port.
// Latency: a request sampled at edge N is answered by a one-cycle ready strobe in the cycle after edge N+LATENCY.
// Backpressure: one request per channel in flight; further requests wait until the requester drops valid after its strobe.
//
// Ports:
//   clk, reset                       single clock, asynchronous active-high reset
//   mem_read_valid/address           per-channel read requests (channel c at [c*ADDR_BITS +: ADDR_BITS])
//   mem_read_ready/data              one-cycle read strobe; data holds until the next read response
//   mem_write_valid/address/data     per-channel write requests (ignored when WRITE_ENABLE = 0)
//   mem_write_ready                  one-cycle write acknowledge strobe
//   load_enable/address/data         host preload, overrides every channel write on the same edge
module mem_responder #(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8,
  parameter int NUM_CHANNELS = 4,
  parameter int LATENCY      = 2,
  parameter int WRITE_ENABLE = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CHANNELS-1:0]           mem_read_valid,
  input  logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_read_address,
  output logic [NUM_CHANNELS-1:0]           mem_read_ready,
  output logic [NUM_CHANNELS*DATA_BITS-1:0] mem_read_data,
  input  logic [NUM_CHANNELS-1:0]           mem_write_valid,
  input  logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_write_address,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0] mem_write_data,
  output logic [NUM_CHANNELS-1:0]           mem_write_ready,
  input  logic                              load_enable,
  input  logic [ADDR_BITS-1:0]              load_address,
  input  logic [DATA_BITS-1:0]              load_data
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP, HOLD} state_t;

  // Array contents, one element per word, visible to every channel's read port.
  logic [DATA_BITS-1:0] mem_word [DEPTH];

  // Write commits presented by the channels on their BUSY->RESP edge.
  logic [NUM_CHANNELS-1:0]           wr_commit;
  logic [NUM_CHANNELS*ADDR_BITS-1:0] wr_addr_all;
  logic [NUM_CHANNELS*DATA_BITS-1:0] wr_dat_all;

  // ---------------------------------------------------------------------------
  // Per-channel request FSMs
  // ---------------------------------------------------------------------------
  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  op_wr_q, op_wr_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic [DATA_BITS-1:0]  wdat_q, wdat_d;
    logic [DATA_BITS-1:0]  rdat_q;
    logic                  rd_vld, wr_vld, fire;

    assign rd_vld = mem_read_valid[c];
    // A read-only build never sees a write request at all.
    assign wr_vld = mem_write_valid[c] && (WRITE_ENABLE != 0);
    assign fire   = (state_q == BUSY) && (cnt_q == 4'd0);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        op_wr_q <= 1'b0;
        addr_q  <= '0;
        wdat_q  <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        op_wr_q <= op_wr_d;
        addr_q  <= addr_d;
        wdat_q  <= wdat_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_wr_d = op_wr_q;
      addr_d  = addr_q;
      wdat_d  = wdat_q;
      case (state_q)
        IDLE: begin
          // Read wins; a losing write keeps valid high and is taken on a later IDLE.
          if (rd_vld) begin
            op_wr_d = 1'b0;
            addr_d  = mem_read_address[c*ADDR_BITS +: ADDR_BITS];
            cnt_d   = LAT_M1;
            state_d = BUSY;
          end else if (wr_vld) begin
            op_wr_d = 1'b1;
            addr_d  = mem_write_address[c*ADDR_BITS +: ADDR_BITS];
            wdat_d  = mem_write_data[c*DATA_BITS +: DATA_BITS];
            cnt_d   = LAT_M1;
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (cnt_q == 4'd0) state_d = RESP;
          else               cnt_d   = cnt_q - 4'd1;
        end
        RESP: state_d = HOLD;
        // Stay here until the requester lets go, so a late valid drop is not a new request.
        HOLD: if (!(op_wr_q ? wr_vld : rd_vld)) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    // Read data is sampled from the array on the BUSY->RESP edge; a write to the
    // same word on that edge lands afterwards, so the old value is returned.
    always_ff @(posedge clk or posedge reset) begin
      if (reset)                  rdat_q <= '0;
      else if (fire && !op_wr_q)  rdat_q <= mem_word[addr_q];
    end

    assign wr_commit[c]                          = fire && op_wr_q;
    assign wr_addr_all[c*ADDR_BITS +: ADDR_BITS] = addr_q;
    assign wr_dat_all[c*DATA_BITS +: DATA_BITS]  = wdat_q;

    assign mem_read_ready[c]                       = (state_q == RESP) && !op_wr_q;
    assign mem_write_ready[c]                      = (state_q == RESP) && op_wr_q && (WRITE_ENABLE != 0);
    assign mem_read_data[c*DATA_BITS +: DATA_BITS] = rdat_q;
  end

  // ---------------------------------------------------------------------------
  // Storage array: each word picks its own writer for the edge
  // ---------------------------------------------------------------------------
  for (genvar w = 0; w < DEPTH; w++) begin : g_word
    logic [DATA_BITS-1:0] word_q, word_d;

    always_comb begin
      word_d = word_q;
      // Scan from the highest channel down so the lowest index wins a collision.
      for (int c = NUM_CHANNELS - 1; c >= 0; c--) begin
        if (wr_commit[c] && (wr_addr_all[c*ADDR_BITS +: ADDR_BITS] == ADDR_BITS'(w)))
          word_d = wr_dat_all[c*DATA_BITS +: DATA_BITS];
      end
      // Host preload overrides every channel write.
      if (load_enable && (load_address == ADDR_BITS'(w)))
        word_d = load_data;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) word_q <= '0;
      else       word_q <= word_d;
    end

    assign mem_word[w] = word_q;
  end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  localparam int AB = 8;
  localparam int DB = 8;
  localparam int NC = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NC-1:0]    rd_vld, wr_vld;
  logic [NC*AB-1:0] rd_addr, wr_addr;
  logic [NC*DB-1:0] wr_dat;
  logic          load_en;
  logic [AB-1:0] load_addr;
  logic [DB-1:0] load_dat;

  logic [NC-1:0]    rd_rdy, wr_rdy, ro_rd_rdy, ro_wr_rdy;
  logic [NC*DB-1:0] rd_dat, ro_rd_dat;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(NC), .LATENCY(2), .WRITE_ENABLE(1)) dut (
    .clk(clk), .reset(reset),
    .mem_read_valid(rd_vld), .mem_read_address(rd_addr),
    .mem_read_ready(rd_rdy), .mem_read_data(rd_dat),
    .mem_write_valid(wr_vld), .mem_write_address(wr_addr), .mem_write_data(wr_dat),
    .mem_write_ready(wr_rdy),
    .load_enable(load_en), .load_address(load_addr), .load_data(load_dat)
  );

  mem_responder #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(NC), .LATENCY(2), .WRITE_ENABLE(0)) dut_ro (
    .clk(clk), .reset(reset),
    .mem_read_valid(rd_vld), .mem_read_address(rd_addr),
    .mem_read_ready(ro_rd_rdy), .mem_read_data(ro_rd_dat),
    .mem_write_valid(wr_vld), .mem_write_address(wr_addr), .mem_write_data(wr_dat),
    .mem_write_ready(ro_wr_rdy),
    .load_enable(load_en), .load_address(load_addr), .load_data(load_dat)
  );

  // Host preload of one word; returns on the negedge after the load edge.
  task automatic do_load(input logic [AB-1:0] a, input logic [DB-1:0] d);
    @(negedge clk);
    load_en = 1'b1; load_addr = a; load_dat = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // One read transaction on channel ch (both instances see it); waits a bounded
  // number of cycles for the strobe and returns to IDLE before exiting.
  task automatic do_read(input int ch, input logic [AB-1:0] a,
                         output logic [DB-1:0] data, output logic ok,
                         output logic [DB-1:0] ro_data, output logic ro_ok);
    ok = 1'b0; ro_ok = 1'b0; data = '0; ro_data = '0;
    @(negedge clk);
    rd_addr[ch*AB +: AB] = a;
    rd_vld[ch] = 1'b1;
    @(negedge clk);
    rd_vld[ch] = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      if (rd_rdy[ch]) begin
        ok = 1'b1;
        data = rd_dat[ch*DB +: DB];
        ro_ok = ro_rd_rdy[ch];
        ro_data = ro_rd_dat[ch*DB +: DB];
      end else begin
        @(negedge clk);
      end
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (rd_rdy !== '0 || wr_rdy !== '0 || ro_rd_rdy !== '0 || ro_wr_rdy !== '0) begin
      errors++;
      $display("FAIL reset_ready: got rd=%b wr=%b ro_rd=%b ro_wr=%b, expected all 0", rd_rdy, wr_rdy, ro_rd_rdy, ro_wr_rdy);
    end
    checks++;
    if (rd_dat !== '0 || ro_rd_dat !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h / %h, expected 0", rd_dat, ro_rd_dat);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (rd_rdy !== '0 || rd_dat !== '0) begin
      errors++;
      $display("FAIL after_release: got rdy=%b data=%h, expected 0", rd_rdy, rd_dat);
    end
  endtask

  task automatic test_preload_read();
    do_load(8'h10, 8'hA5);
    @(negedge clk);
    rd_addr[0 +: AB] = 8'h10;
    rd_vld[0] = 1'b1;
    @(negedge clk);              // after acceptance edge N
    rd_vld[0] = 1'b0;
    checks++;
    if (rd_rdy[0] !== 1'b0) begin errors++; $display("FAIL single_n0: got ready %b, expected 0", rd_rdy[0]); end
    @(negedge clk);              // after N+1
    checks++;
    if (rd_rdy[0] !== 1'b0) begin errors++; $display("FAIL single_n1: got ready %b, expected 0", rd_rdy[0]); end
    @(negedge clk);              // after N+2
    checks++;
    if (rd_rdy[0] !== 1'b1 || rd_dat[0 +: DB] !== 8'hA5) begin
      errors++;
      $display("FAIL single_n2: got ready %b data %h, expected 1 a5", rd_rdy[0], rd_dat[0 +: DB]);
    end
    @(negedge clk);              // after N+3
    checks++;
    if (rd_rdy[0] !== 1'b0 || rd_dat[0 +: DB] !== 8'hA5) begin
      errors++;
      $display("FAIL single_hold: got ready %b data %h, expected 0 a5", rd_rdy[0], rd_dat[0 +: DB]);
    end
    @(negedge clk);
  endtask

  task automatic test_parallel_reads();
    for (int i = 0; i < 4; i++) do_load(AB'(i), DB'(i + 1));
    @(negedge clk);
    rd_addr = {8'd3, 8'd2, 8'd1, 8'd0};
    rd_vld = 4'hF;
    @(negedge clk);
    rd_vld = 4'h0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (rd_rdy !== 4'hF) begin errors++; $display("FAIL parallel_ready: got %b, expected 1111", rd_rdy); end
    checks++;
    if (rd_dat !== 32'h04030201) begin errors++; $display("FAIL parallel_data: got %h, expected 04030201", rd_dat); end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_write_collision();
    logic [DB-1:0] d, rod;
    logic ok, rook;
    for (int round = 0; round < 2; round++) begin
      @(negedge clk);
      wr_addr[1*AB +: AB] = 8'h20; wr_dat[1*DB +: DB] = 8'h11;
      wr_addr[2*AB +: AB] = 8'h20; wr_dat[2*DB +: DB] = 8'h22;
      wr_vld = 4'b0110;
      @(negedge clk);            // after N
      wr_vld = 4'b0000;
      @(negedge clk);            // after N+1
      if (round == 1) begin load_en = 1'b1; load_addr = 8'h20; load_dat = 8'h33; end
      @(negedge clk);            // after N+2: commit edge
      load_en = 1'b0;
      checks++;
      if (wr_rdy !== 4'b0110) begin errors++; $display("FAIL collide_wr_ready%0d: got %b, expected 0110", round, wr_rdy); end
      @(negedge clk);
      @(negedge clk);
      do_read(0, 8'h20, d, ok, rod, rook);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL collide_read%0d: no read strobe within bound", round);
      end else if (d !== ((round == 0) ? 8'h11 : 8'h33)) begin
        errors++; $display("FAIL collide_read%0d: got %h, expected %h", round, d, (round == 0) ? 8'h11 : 8'h33);
      end
    end
  endtask

  task automatic test_late_valid_drop();
    logic [15:0] seen;
    seen = '0;
    @(negedge clk);
    rd_addr[0 +: AB] = 8'h10;
    rd_vld[0] = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      seen[k] = rd_rdy[0];
      if (k == 6) rd_vld[0] = 1'b0;
      if (k == 7) rd_vld[0] = 1'b1;
      if (k == 8) rd_vld[0] = 1'b0;
    end
    checks++;
    if (seen !== 16'h0408) begin errors++; $display("FAIL late_drop_pulses: got %h, expected 0408", seen); end
    checks++;
    if (rd_dat[0 +: DB] !== 8'hA5) begin errors++; $display("FAIL late_drop_data: got %h, expected a5", rd_dat[0 +: DB]); end
  endtask

  task automatic test_read_only();
    int main_cnt, ro_cnt;
    logic [DB-1:0] d, rod;
    logic ok, rook;
    main_cnt = 0; ro_cnt = 0;
    @(negedge clk);
    wr_addr[0 +: AB] = 8'h05; wr_dat[0 +: DB] = 8'hFF;
    wr_vld[0] = 1'b1;
    @(negedge clk);
    wr_vld[0] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (wr_rdy[0]) main_cnt++;
      if (ro_wr_rdy[0]) ro_cnt++;
      @(negedge clk);
    end
    checks++;
    if (ro_cnt != 0) begin errors++; $display("FAIL ro_write_ready: got %0d pulses, expected 0", ro_cnt); end
    checks++;
    if (main_cnt != 1) begin errors++; $display("FAIL rw_write_ready: got %0d pulses, expected 1", main_cnt); end
    do_read(0, 8'h05, d, ok, rod, rook);
    checks++;
    if (!ok || d !== 8'hFF) begin errors++; $display("FAIL rw_read_05: got ok=%b data %h, expected 1 ff", ok, d); end
    checks++;
    if (!rook || rod !== 8'h00) begin errors++; $display("FAIL ro_read_05: got ok=%b data %h, expected 1 00", rook, rod); end
  endtask

  task automatic test_reset_mid_op();
    int pulses;
    logic [DB-1:0] d, rod;
    logic ok, rook;
    pulses = 0;
    @(negedge clk);
    rd_addr[3*AB +: AB] = 8'h10;
    rd_vld[3] = 1'b1;
    @(negedge clk);              // ch3 now BUSY
    rd_vld[3] = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (rd_rdy !== '0 || wr_rdy !== '0) begin errors++; $display("FAIL midreset_ready: got rd=%b wr=%b, expected 0", rd_rdy, wr_rdy); end
    checks++;
    if (rd_dat !== '0) begin errors++; $display("FAIL midreset_data: got %h, expected 0", rd_dat); end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rd_rdy[3]) pulses++;
    end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL midreset_no_resp: got %0d pulses, expected 0", pulses); end
    do_read(3, 8'h10, d, ok, rod, rook);
    checks++;
    if (!ok || d !== 8'h00) begin errors++; $display("FAIL midreset_read_10: got ok=%b data %h, expected 1 00", ok, d); end
    do_read(1, 8'h00, d, ok, rod, rook);
    checks++;
    if (!ok || d !== 8'h00) begin errors++; $display("FAIL midreset_read_00: got ok=%b data %h, expected 1 00", ok, d); end
  endtask

  initial begin
    rd_vld = '0; wr_vld = '0; rd_addr = '0; wr_addr = '0; wr_dat = '0;
    load_en = 1'b0; load_addr = '0; load_dat = '0;
    test_reset();
    test_preload_read();
    test_parallel_reads();
    test_write_collision();
    test_late_valid_drop();
    test_read_only();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
